// File: rtl/xor_resp_checker_pkg.sv
// rtl/xor_resp_checker_pkg.sv - shared types and constants for the XOR response checker
package xor_resp_checker_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    localparam logic [3:0] COV_ALL = 4'hF;

    function automatic logic xor_expect(input logic a, input logic b);
        return a ^ b;
    endfunction

endpackage

// File: rtl/xor_resp_checker_if.sv
// rtl/xor_resp_checker_if.sv - sample strobe and result bundle of the XOR response checker
interface xor_resp_checker_if #(
    parameter int CNT_W = 8
);
    logic             start;
    logic             in_valid;
    logic             a;
    logic             b;
    logic             y;
    logic             busy;
    logic             done;
    logic             pass;
    logic             timeout;
    logic [3:0]       coverage;
    logic [CNT_W-1:0] vec_cnt;
    logic [CNT_W-1:0] err_cnt;
    logic [2:0]       first_err;
    logic             first_err_vld;

    modport master (
        output start, in_valid, a, b, y,
        input  busy, done, pass, timeout, coverage, vec_cnt, err_cnt, first_err, first_err_vld
    );

    modport slave (
        input  start, in_valid, a, b, y,
        output busy, done, pass, timeout, coverage, vec_cnt, err_cnt, first_err, first_err_vld
    );
endinterface

// File: rtl/xor_resp_checker_sat_counter.sv
// rtl/xor_resp_checker_sat_counter.sv - saturating up-counter with synchronous clear
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);
    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;
endmodule

// File: rtl/xor_resp_checker.sv
// rtl/xor_resp_checker.sv - checks strobed XOR gate samples, tracks coverage, errors and idle timeout
module xor_resp_checker
    import xor_resp_checker_pkg::*;
#(
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    xor_resp_checker_if.slave     bus
);
    localparam int IDLE_W = $clog2(TIMEOUT + 1);

    state_e            state_q, state_d;
    logic [3:0]        cov_q, cov_d;
    logic [2:0]        ferr_q, ferr_d;
    logic              ferr_vld_q, ferr_vld_d;
    logic              pass_q, pass_d;
    logic              timeout_q, timeout_d;
    logic [IDLE_W-1:0] idle_q, idle_d;

    logic              cnt_clr;
    logic              vec_inc;
    logic              err_inc;
    logic              mismatch;
    logic [1:0]        cov_idx;
    logic [CNT_W-1:0]  vec_cnt;
    logic [CNT_W-1:0]  err_cnt;

    assign mismatch = bus.y != xor_expect(bus.a, bus.b);
    assign cov_idx  = {bus.a, bus.b};

    always_comb begin
        state_d    = state_q;
        cov_d      = cov_q;
        ferr_d     = ferr_q;
        ferr_vld_d = ferr_vld_q;
        pass_d     = pass_q;
        timeout_d  = timeout_q;
        idle_d     = idle_q;
        cnt_clr    = 1'b0;
        vec_inc    = 1'b0;
        err_inc    = 1'b0;

        if (bus.start) begin
            // start wins in every state; a sample in the same cycle is dropped
            state_d    = ST_CHECK;
            cov_d      = '0;
            ferr_d     = '0;
            ferr_vld_d = 1'b0;
            pass_d     = 1'b0;
            timeout_d  = 1'b0;
            idle_d     = '0;
            cnt_clr    = 1'b1;
        end else if (state_q == ST_CHECK) begin
            if (bus.in_valid) begin
                vec_inc         = 1'b1;
                cov_d[cov_idx]  = 1'b1;
                idle_d          = '0;
                if (mismatch) begin
                    err_inc = 1'b1;
                    if (!ferr_vld_q) begin
                        ferr_d     = {bus.a, bus.b, bus.y};
                        ferr_vld_d = 1'b1;
                    end
                end
            end else begin
                idle_d = idle_q + IDLE_W'(1);
            end

            // err_cnt is still the pre-update value, so fold in this cycle's mismatch
            if (cov_d == COV_ALL) begin
                state_d = ST_DONE;
                pass_d  = (err_cnt == '0) && !(bus.in_valid && mismatch);
            end else if (idle_d == IDLE_W'(TIMEOUT)) begin
                state_d   = ST_DONE;
                timeout_d = 1'b1;
                pass_d    = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cov_q      <= '0;
            ferr_q     <= '0;
            ferr_vld_q <= 1'b0;
            pass_q     <= 1'b0;
            timeout_q  <= 1'b0;
            idle_q     <= '0;
        end else begin
            state_q    <= state_d;
            cov_q      <= cov_d;
            ferr_q     <= ferr_d;
            ferr_vld_q <= ferr_vld_d;
            pass_q     <= pass_d;
            timeout_q  <= timeout_d;
            idle_q     <= idle_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_vec_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .inc   (vec_inc),
        .cnt   (vec_cnt)
    );

    sat_counter #(.W(CNT_W)) u_err_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .inc   (err_inc),
        .cnt   (err_cnt)
    );

    assign bus.busy          = (state_q == ST_CHECK);
    assign bus.done          = (state_q == ST_DONE);
    assign bus.pass          = pass_q;
    assign bus.timeout       = timeout_q;
    assign bus.coverage      = cov_q;
    assign bus.vec_cnt       = vec_cnt;
    assign bus.err_cnt       = err_cnt;
    assign bus.first_err     = ferr_q;
    assign bus.first_err_vld = ferr_vld_q;
endmodule

// File: tb/tb_xor_resp_checker.sv
// tb/tb_xor_resp_checker.sv - self-checking bench for xor_resp_checker (CNT_W=8 and CNT_W=2 instances)
module tb_xor_resp_checker;
    localparam int TMO = 64;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0, in_valid = 1'b0, a = 1'b0, b = 1'b0, y = 1'b0;

    int total = 0;
    int bad   = 0;

    xor_resp_checker_if #(.CNT_W(8)) bus8 ();
    xor_resp_checker_if #(.CNT_W(2)) bus2 ();

    assign bus8.start = start;  assign bus8.in_valid = in_valid;
    assign bus8.a = a;          assign bus8.b = b;  assign bus8.y = y;
    assign bus2.start = start;  assign bus2.in_valid = in_valid;
    assign bus2.a = a;          assign bus2.b = b;  assign bus2.y = y;

    xor_resp_checker #(.CNT_W(8), .TIMEOUT(TMO)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
    xor_resp_checker #(.CNT_W(2), .TIMEOUT(TMO)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

    always #5 clk = ~clk;

    // Reference model: unbounded integer counts, saturated only when compared
    bit       m_active, m_done, m_pass, m_to, m_fvld;
    bit [3:0] m_cov;
    bit [2:0] m_ferr;
    int       m_vec, m_err, m_idle;

    function automatic int sat(input int v, input int maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    task automatic model_edge();
        if (!rst_n) begin
            m_active = 0; m_done = 0; m_pass = 0; m_to = 0; m_fvld = 0;
            m_cov = 0; m_ferr = 0; m_vec = 0; m_err = 0; m_idle = 0;
        end else if (start) begin
            m_active = 1; m_done = 0; m_pass = 0; m_to = 0; m_fvld = 0;
            m_cov = 0; m_ferr = 0; m_vec = 0; m_err = 0; m_idle = 0;
        end else if (m_active) begin
            if (in_valid) begin
                m_vec++;
                m_cov = m_cov | (4'b0001 << (2 * int'(a) + int'(b)));
                if (y != (a ^ b)) begin
                    m_err++;
                    if (!m_fvld) begin
                        m_ferr = {a, b, y};
                        m_fvld = 1;
                    end
                end
                m_idle = 0;
            end else begin
                m_idle++;
            end
            if (m_cov == 4'hF) begin
                m_active = 0; m_done = 1; m_pass = (m_err == 0);
            end else if (m_idle == TMO) begin
                m_active = 0; m_done = 1; m_to = 1; m_pass = 0;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("busy",      32'(bus8.busy),          32'(m_active));
        chk("done",      32'(bus8.done),          32'(m_done));
        chk("pass",      32'(bus8.pass),          32'(m_pass));
        chk("timeout",   32'(bus8.timeout),       32'(m_to));
        chk("coverage",  32'(bus8.coverage),      32'(m_cov));
        chk("vec_cnt",   32'(bus8.vec_cnt),       32'(sat(m_vec, 255)));
        chk("err_cnt",   32'(bus8.err_cnt),       32'(sat(m_err, 255)));
        chk("first_err", 32'(bus8.first_err),     32'(m_ferr));
        chk("ferr_vld",  32'(bus8.first_err_vld), 32'(m_fvld));
        chk("w2_vec",    32'(bus2.vec_cnt),       32'(sat(m_vec, 3)));
        chk("w2_err",    32'(bus2.err_cnt),       32'(sat(m_err, 3)));
        chk("w2_done",   32'(bus2.done),          32'(m_done));
        chk("w2_pass",   32'(bus2.pass),          32'(m_pass));
    endtask

    task automatic step(input logic st, input logic iv, input logic ia, input logic ib, input logic iy);
        start = st; in_valid = iv; a = ia; b = ib; y = iy;
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic samp(input logic ia, input logic ib, input logic iy);
        step(1'b0, 1'b1, ia, ib, iy);
    endtask

    initial begin
        int n;
        int len;
        logic iv;
        logic ia;
        logic ib;

        model_edge();
        step(0, 0, 0, 0, 0);
        step(0, 1, 1, 1, 1);
        rst_n = 1'b1;

        // 1: all four correct vectors
        step(1, 0, 0, 0, 0);
        samp(0, 0, 0); samp(0, 1, 1); samp(1, 0, 1); samp(1, 1, 0);
        chk("t1_pass", 32'(bus8.pass), 32'd1);
        chk("t1_vec",  32'(bus8.vec_cnt), 32'd4);
        step(0, 1, 0, 0, 1);

        // 2: two mismatches, first is {0,1,0}
        step(1, 0, 0, 0, 0);
        samp(0, 0, 0); samp(0, 1, 0); samp(1, 0, 1); samp(1, 1, 1);
        chk("t2_err",  32'(bus8.err_cnt), 32'd2);
        chk("t2_ferr", 32'(bus8.first_err), 32'b010);

        // 3: partial coverage then idle timeout
        step(1, 0, 0, 0, 0);
        samp(0, 0, 0); samp(1, 1, 0);
        n = 0;
        while (!bus8.done && n < 200) begin
            step(0, 0, 0, 0, 0);
            n++;
        end
        chk("t3_latency", 32'(n), 32'(TMO));
        chk("t3_cov",     32'(bus8.coverage), 32'b1001);

        // 4: restart mid-run discards earlier samples
        step(1, 0, 0, 0, 0);
        samp(0, 0, 0); samp(0, 0, 0); samp(0, 0, 0); samp(0, 1, 1);
        step(1, 1, 1, 1, 1);
        samp(0, 0, 0); samp(0, 1, 1); samp(1, 0, 1); samp(1, 1, 0);
        chk("t4_vec", 32'(bus8.vec_cnt), 32'd4);

        // 5: reset mid scenario 2, samples ignored until next start
        step(1, 0, 0, 0, 0);
        samp(0, 0, 0); samp(0, 1, 0);
        rst_n = 1'b0;
        step(0, 1, 1, 0, 1);
        chk("t5_rst_err", 32'(bus8.err_cnt), 32'd0);
        rst_n = 1'b1;
        samp(1, 1, 1); samp(0, 0, 0); samp(0, 1, 1); samp(1, 0, 1);

        // 6: saturation of both counters at CNT_W=2
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) samp(0, 0, 1);
        samp(0, 1, 1); samp(1, 0, 1); samp(1, 1, 0);
        chk("t6_w2_err", 32'(bus2.err_cnt), 32'd3);
        chk("t6_w2_vec", 32'(bus2.vec_cnt), 32'd3);

        // randomized runs with occasional restarts and idle gaps
        for (int r = 0; r < 25; r++) begin
            step(1, 0, 0, 0, 0);
            len = 0;
            while (m_active && len < 150) begin
                iv = ($urandom_range(0, 3) != 0);
                ia = 1'($urandom);
                ib = 1'($urandom);
                if ($urandom_range(0, 9) == 0) begin
                    for (int k = 0; k < int'($urandom_range(5, 70)) && m_active; k++)
                        step(0, 0, 0, 0, 0);
                end
                step(($urandom_range(0, 40) == 0), iv, ia, ib,
                     (ia ^ ib) ^ ($urandom_range(0, 6) == 0));
                len++;
            end
            step(0, 1, 1, 1, 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
